// File: rtl/acp_pkg.sv
// Shared constants, AXI encodings and FSM state type for the ACP burst writer.
package acp_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned STRB_W     = 8;
    localparam int unsigned BEATS_W    = 16;
    localparam int unsigned BLEN_W     = 5;
    localparam int unsigned PAGE_BYTES = 4096;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Coherent writes allocate through the SCU; non-coherent ones are plain bufferable.
    localparam logic [3:0] AWCACHE_COHERENT = 4'b1111;
    localparam logic [4:0] AWUSER_COHERENT  = 5'b00001;
    localparam logic [3:0] AWCACHE_NONCOH   = 4'b0011;
    localparam logic [4:0] AWUSER_NONCOH    = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/acp_burst_writer_if.sv
// Command, stream, status and ACP AXI write channels of the burst writer.
interface acp_burst_writer_if import acp_pkg::*; ();

    logic [ADDR_W-1:0]  cmd_addr;
    logic [BEATS_W-1:0] cmd_beats;
    logic               cmd_valid;
    logic               cmd_ready;

    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_ready;

    logic               done;
    logic               busy;
    logic               err;

    logic [ADDR_W-1:0]  M_AXI_AWADDR;
    logic [7:0]         M_AXI_AWLEN;
    logic [2:0]         M_AXI_AWSIZE;
    logic [1:0]         M_AXI_AWBURST;
    logic [3:0]         M_AXI_AWCACHE;
    logic [4:0]         M_AXI_AWUSER;
    logic [2:0]         M_AXI_AWPROT;
    logic               M_AXI_AWVALID;
    logic               M_AXI_AWREADY;

    logic [DATA_W-1:0]  M_AXI_WDATA;
    logic [STRB_W-1:0]  M_AXI_WSTRB;
    logic               M_AXI_WLAST;
    logic               M_AXI_WVALID;
    logic               M_AXI_WREADY;

    logic [1:0]         M_AXI_BRESP;
    logic               M_AXI_BVALID;
    logic               M_AXI_BREADY;

    modport master (
        input  cmd_addr, cmd_beats, cmd_valid, s_data, s_valid,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output cmd_ready, s_ready, done, busy, err,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        output M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_BREADY
    );

    modport slave (
        output cmd_addr, cmd_beats, cmd_valid, s_data, s_valid,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  cmd_ready, s_ready, done, busy, err,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        input  M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_BREADY
    );

endinterface

// File: rtl/acp_burst_len_calc.sv
// Beats for the next burst: min(BURST_LEN, remaining, beats left in the 4 KB page).
module acp_burst_len_calc import acp_pkg::*; #(
    parameter int unsigned BURST_LEN = 16
) (
    input  logic [11:0]         addr_i,
    input  logic [BEATS_W-1:0]  remaining_i,
    output logic [BLEN_W-1:0]   burst_o
);

    logic [12:0]        page_left_c;
    logic [BEATS_W-1:0] page_beats_c;
    logic [BEATS_W-1:0] lim_c;

    assign page_left_c  = 13'(PAGE_BYTES) - {1'b0, addr_i};
    assign page_beats_c = BEATS_W'(page_left_c >> 3);

    always_comb begin
        lim_c = BEATS_W'(BURST_LEN);
        if (remaining_i < lim_c) begin
            lim_c = remaining_i;
        end
        if (page_beats_c < lim_c) begin
            lim_c = page_beats_c;
        end
    end

    assign burst_o = BLEN_W'(lim_c);

endmodule

// File: rtl/acp_burst_writer.sv
// Splits a (start address, beat count) command into 4 KB-safe AXI INCR write bursts on the ACP.
// Define ACP_BURST_WRITER_COHERENT_EN for coherent SCU-allocating writes; default is non-coherent.
module acp_burst_writer import acp_pkg::*; #(
    parameter int unsigned BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    acp_burst_writer_if.master bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEATS_W-1:0]  rem_q, rem_d;
    logic [BLEN_W-1:0]   burst_q, burst_d;
    logic [BLEN_W-1:0]   beat_q, beat_d;
    logic [7:0]          awlen_q, awlen_d;
    logic                awvalid_q, awvalid_d;
    logic                wlast_q, wlast_d;
    logic                bready_q, bready_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic [ADDR_W-1:0]   load_addr_c;
    logic [BEATS_W-1:0]  load_rem_c;
    logic [BLEN_W-1:0]   next_burst_c;
    logic                cmd_fire_c, aw_fire_c, w_fire_c, b_fire_c;

    // Address/remaining the next burst starts from: fresh command in IDLE, else after the current burst.
    assign load_addr_c = (state_q == ST_IDLE) ? (bus.cmd_addr & ~ADDR_W'(7))
                                              : addr_q + (ADDR_W'(burst_q) << 3);
    assign load_rem_c  = (state_q == ST_IDLE) ? bus.cmd_beats
                                              : rem_q - BEATS_W'(burst_q);

    acp_burst_len_calc #(.BURST_LEN(BURST_LEN)) u_len_calc (
        .addr_i      (load_addr_c[11:0]),
        .remaining_i (load_rem_c),
        .burst_o     (next_burst_c)
    );

    assign cmd_fire_c = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
    assign aw_fire_c  = (state_q == ST_ADDR) && bus.M_AXI_AWREADY;
    assign w_fire_c   = (state_q == ST_DATA) && bus.s_valid && bus.M_AXI_WREADY;
    assign b_fire_c   = (state_q == ST_RESP) && bus.M_AXI_BVALID;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    addr_d = load_addr_c;
                    rem_d  = load_rem_c;
                    err_d  = 1'b0;
                    if (load_rem_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_ADDR;
                        busy_d    = 1'b1;
                        awvalid_d = 1'b1;
                        burst_d   = next_burst_c;
                        awlen_d   = 8'(next_burst_c - BLEN_W'(1));
                    end
                end
            end
            ST_ADDR: begin
                if (aw_fire_c) begin
                    state_d   = ST_DATA;
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    wlast_d   = (burst_q == BLEN_W'(1));
                end
            end
            ST_DATA: begin
                if (w_fire_c) begin
                    beat_d  = beat_q + BLEN_W'(1);
                    wlast_d = ((beat_q + BLEN_W'(2)) == burst_q);
                    if (wlast_q) begin
                        state_d  = ST_RESP;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (b_fire_c) begin
                    bready_d = 1'b0;
                    err_d    = err_q | (bus.M_AXI_BRESP != AXI_RESP_OKAY);
                    addr_d   = load_addr_c;
                    rem_d    = load_rem_c;
                    if (load_rem_c != '0) begin
                        state_d   = ST_ADDR;
                        awvalid_d = 1'b1;
                        burst_d   = next_burst_c;
                        awlen_d   = 8'(next_burst_c - BLEN_W'(1));
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.err           = err_q;

    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWLEN   = awlen_q;
    assign bus.M_AXI_AWSIZE  = AXI_SIZE_8B;
    assign bus.M_AXI_AWBURST = AXI_BURST_INCR;
    assign bus.M_AXI_AWPROT  = AXI_PROT_DATA;
    assign bus.M_AXI_AWVALID = awvalid_q;
`ifdef ACP_BURST_WRITER_COHERENT_EN
    assign bus.M_AXI_AWCACHE = AWCACHE_COHERENT;
    assign bus.M_AXI_AWUSER  = AWUSER_COHERENT;
`else
    assign bus.M_AXI_AWCACHE = AWCACHE_NONCOH;
    assign bus.M_AXI_AWUSER  = AWUSER_NONCOH;
`endif

    // W channel is a combinational pass-through while in DATA so back-to-back beats have no bubbles.
    assign bus.M_AXI_WDATA   = bus.s_data;
    assign bus.M_AXI_WSTRB   = '1;
    assign bus.M_AXI_WLAST   = wlast_q;
    assign bus.M_AXI_WVALID  = (state_q == ST_DATA) && bus.s_valid;
    assign bus.s_ready       = (state_q == ST_DATA) && bus.M_AXI_WREADY;
    assign bus.M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_acp_burst_writer.sv
// Randomized bench for acp_burst_writer against a burst-splitting reference model.
module tb_acp_burst_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acp_burst_writer_if bus();

    acp_burst_writer #(.BURST_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid     = 1'b0;
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY  = 1'b0;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    endtask

    // One full command: reference bursts come from min(16, remaining, page beats) arithmetic.
    task automatic run_cmd(input logic [31:0] addr, input logic [15:0] beats,
                           input bit stall, input int bad_idx);
        logic [31:0] a;
        int          rem, b, page;
        logic [31:0] ea[$];
        int          el[$];
        logic [63:0] dq[$];
        int          aw_idx = 0, b_idx = 0, beat_in = 0, cyc = 0, last_b_cyc = -10;
        bit          outstanding = 0, b_pending = 0, exp_err = 0, done_seen = 0;

        a   = addr & ~32'h7;
        rem = int'(beats);
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 8;
            b = 16;
            if (rem < b) b = rem;
            if (page < b) b = page;
            ea.push_back(a);
            el.push_back(b);
            a   = a + 32'(b * 8);
            rem = rem - b;
        end
        for (int i = 0; i < int'(beats); i++) dq.push_back({$urandom, $urandom});

        wait_cmd_ready();
        bus.cmd_addr  = addr;
        bus.cmd_beats = beats;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("err_clear_on_accept", 64'(bus.err), 64'd0);

        if (beats == 16'd0) begin
            check_eq("zero_done", 64'(bus.done), 64'd1);
            check_eq("zero_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
            check_eq("zero_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
            check_eq("zero_done_pulse", 64'(bus.done), 64'd0);
            check_eq("zero_awvalid2", 64'(bus.M_AXI_AWVALID), 64'd0);
            return;
        end
        check_eq("aw_latency", 64'(bus.M_AXI_AWVALID), 64'd1);
        check_eq("busy_after_accept", 64'(bus.busy), 64'd1);

        while (!done_seen && cyc < 4000) begin
            if (bus.done) begin
                done_seen = 1;
                check_eq("done_latency", 64'(cyc), 64'(last_b_cyc + 1));
                check_eq("err_at_done", 64'(bus.err), 64'(exp_err));
                check_eq("busy_at_done", 64'(bus.busy), 64'd0);
                check_eq("cmd_ready_at_done", 64'(bus.cmd_ready), 64'd1);
                check_eq("burst_count", 64'(aw_idx), 64'(ea.size()));
                check_eq("beats_left", 64'(dq.size()), 64'd0);
                break;
            end
            check_eq("aw_while_outstanding", 64'(bus.M_AXI_AWVALID && outstanding), 64'd0);

            bus.M_AXI_AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.M_AXI_WREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid       = (dq.size() > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.s_data        = (dq.size() > 0) ? dq[0] : 64'd0;
            bus.M_AXI_BVALID  = b_pending && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.M_AXI_BRESP   = (b_idx == bad_idx) ? 2'b10 : 2'b00;
            #1;

            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                if (aw_idx < ea.size()) begin
                    check_eq("awaddr", 64'(bus.M_AXI_AWADDR), 64'(ea[aw_idx]));
                    check_eq("awlen", 64'(bus.M_AXI_AWLEN), 64'(el[aw_idx] - 1));
                end else begin
                    check_eq("aw_extra_burst", 64'd1, 64'd0);
                end
                aw_idx++;
                outstanding = 1;
                beat_in = 0;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                check_eq("s_ready_follows", 64'(bus.s_ready), 64'd1);
                check_eq("wdata", bus.M_AXI_WDATA, dq[0]);
                if (aw_idx > 0 && aw_idx <= el.size())
                    check_eq("wlast", 64'(bus.M_AXI_WLAST), 64'(beat_in == el[aw_idx - 1] - 1));
                if (aw_idx > 0 && aw_idx <= el.size() && beat_in == el[aw_idx - 1] - 1)
                    b_pending = 1;
                void'(dq.pop_front());
                beat_in++;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
                if (b_idx == bad_idx) exp_err = 1;
                b_pending   = 0;
                outstanding = 0;
                b_idx++;
                last_b_cyc  = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) check_eq("done_timeout", 64'd0, 64'd1);

        idle_inputs();
        @(negedge clk);
        check_eq("done_pulse_width", 64'(bus.done), 64'd0);
        check_eq("err_sticky", 64'(bus.err), 64'(exp_err));
    endtask

    task automatic check_reset_values(input string phase);
        check_eq({phase, "_done"},    64'(bus.done), 64'd0);
        check_eq({phase, "_busy"},    64'(bus.busy), 64'd0);
        check_eq({phase, "_err"},     64'(bus.err), 64'd0);
        check_eq({phase, "_awvalid"}, 64'(bus.M_AXI_AWVALID), 64'd0);
        check_eq({phase, "_wvalid"},  64'(bus.M_AXI_WVALID), 64'd0);
        check_eq({phase, "_wlast"},   64'(bus.M_AXI_WLAST), 64'd0);
        check_eq({phase, "_bready"},  64'(bus.M_AXI_BREADY), 64'd0);
        check_eq({phase, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        check_eq({phase, "_awaddr"},  64'(bus.M_AXI_AWADDR), 64'd0);
        check_eq({phase, "_awlen"},   64'(bus.M_AXI_AWLEN), 64'd0);
        check_eq({phase, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        int          n;

        idle_inputs();
        bus.cmd_addr  = '0;
        bus.cmd_beats = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        check_eq("awsize", 64'(bus.M_AXI_AWSIZE), 64'h3);
        check_eq("awburst", 64'(bus.M_AXI_AWBURST), 64'h1);
        check_eq("awprot", 64'(bus.M_AXI_AWPROT), 64'h0);
        check_eq("wstrb", 64'(bus.M_AXI_WSTRB), 64'hFF);
`ifdef ACP_BURST_WRITER_COHERENT_EN
        check_eq("awcache", 64'(bus.M_AXI_AWCACHE), 64'hF);
        check_eq("awuser", 64'(bus.M_AXI_AWUSER), 64'h1);
`else
        check_eq("awcache", 64'(bus.M_AXI_AWCACHE), 64'h3);
        check_eq("awuser", 64'(bus.M_AXI_AWUSER), 64'h0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_eq("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);

        run_cmd(32'h1000_0000, 16'd40, 1'b0, -1);
        run_cmd(32'h1000_0FE0, 16'd8, 1'b0, -1);
        run_cmd(32'h1000_0000, 16'd0, 1'b0, -1);
        run_cmd($urandom & 32'hFFFF_FFF8, 16'd16, 1'b1, -1);
        run_cmd(32'h1000_0000, 16'd40, 1'b1, 1);
        run_cmd(32'h2000_0008, 16'd5, 1'b1, -1);
        run_cmd(32'hFFFF_FFF3, 16'd4, 1'b1, -1);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            ra[11:0] = 12'(4096 - 8 * int'($urandom_range(1, 24)));
            run_cmd(ra, 16'($urandom_range(0, 70)), 1'b1, int'($urandom_range(0, 5)) - 1);
        end

        // Reset in the middle of the data phase.
        wait_cmd_ready();
        bus.cmd_addr  = 32'h3000_0000;
        bus.cmd_beats = 16'd32;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        bus.M_AXI_AWREADY = 1'b1;
        bus.s_valid       = 1'b1;
        bus.M_AXI_WREADY  = 1'b0;
        #1;
        while (!bus.M_AXI_WVALID && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("reached_data", 64'(bus.M_AXI_WVALID), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.M_AXI_WREADY = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_eq("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);

        run_cmd(32'h4000_0F00, 16'd33, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
